// File: rtl/score_bcd_counter_if.sv
// ---------------------------------------------------------------------------
// score_bcd_counter_if
//   Bundles the game-control inputs and the score outputs of the BCD score
//   keeper so the game logic and the score block connect through one port.
//
//   Signals
//     clear      game control -> score   synchronous score clear (new game)
//     pause      game control -> score   new hits ignored while high
//     hit        game control -> score   collision level, one hit per rise
//     thous      score -> display        BCD thousands digit
//     huns       score -> display        BCD hundreds digit
//     tens       score -> display        BCD tens digit
//     ones       score -> display        BCD ones digit
//     busy       score -> display        an addition is rippling
//     saturated  score -> display        sticky, score clamped at 9999
//
//   Modports
//     master     the game/control side (drives clear/pause/hit)
//     slave      the score counter itself
// ---------------------------------------------------------------------------
interface score_bcd_counter_if;
  logic       clear;
  logic       pause;
  logic       hit;
  logic [3:0] thous;
  logic [3:0] huns;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       saturated;

  modport master (
    output clear, pause, hit,
    input  thous, huns, tens, ones, busy, saturated
  );

  modport slave (
    input  clear, pause, hit,
    output thous, huns, tens, ones, busy, saturated
  );
endinterface

// File: rtl/score_bcd_counter.sv
// ---------------------------------------------------------------------------
// score_bcd_counter
//   Game score keeper for the brick-breaker design. Every rising edge of the
//   collision level adds POINTS to a 4-digit BCD score. The carry ripples one
//   digit per clock through a small FSM, so no wide BCD adder is built; hits
//   that arrive while a ripple is in flight are queued in a saturating
//   pending counter and replayed afterwards.
//
//   Parameters
//     POINTS   BCD points added per hit, legal range 1..9
//     PEND_W   width of the pending-hit counter (saturates at 2**PEND_W-1)
//
//   Ports
//     clk      master clock
//     rst      asynchronous, active-low reset
//     bus      score_bcd_counter_if.slave
//                clear/pause/hit in, thous/huns/tens/ones/busy/saturated out
// ---------------------------------------------------------------------------
module score_bcd_counter #(
  parameter int unsigned POINTS = 1,
  parameter int unsigned PEND_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  score_bcd_counter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADD_ONES,
    ADD_TENS,
    ADD_HUNS,
    ADD_THOUS
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);
  localparam logic [3:0]        POINTS4    = 4'(POINTS);
  localparam logic [4:0]        POINTS5    = 5'(POINTS);

  state_t            state;
  state_t            state_next;
  logic              hit_d;
  logic              hit_edge;
  logic [PEND_W-1:0] pending;
  logic [PEND_W-1:0] pending_next;
  logic [3:0]        ones_q;
  logic [3:0]        tens_q;
  logic [3:0]        huns_q;
  logic [3:0]        thous_q;
  logic [3:0]        ones_next;
  logic [3:0]        tens_next;
  logic [3:0]        huns_next;
  logic [3:0]        thous_next;
  logic              sat_q;
  logic              sat_next;
  logic [4:0]        ones_sum;
  logic [3:0]        ones_wrap;

  // A hit counts once per rising edge of the collision level, and only while
  // the game is running; holding hit high therefore scores a single hit.
  assign hit_edge = bus.hit & ~hit_d & ~bus.pause;

  // The ones digit is the only place POINTS is added. The 5-bit sum decides
  // whether a carry is needed; the wrapped value is formed in 4-bit modulo
  // arithmetic, which is exact because the wrapped result is always 0..8.
  assign ones_sum  = {1'b0, ones_q} + POINTS5;
  assign ones_wrap = ones_q + POINTS4 - 4'd10;

  // State, digit, pending and sticky-saturation registers. The hit delay
  // register keeps tracking the input even during clear so that a level held
  // across a clear is not seen as a fresh hit afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      hit_d   <= 1'b0;
      pending <= '0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      huns_q  <= 4'd0;
      thous_q <= 4'd0;
      sat_q   <= 1'b0;
    end else begin
      state   <= state_next;
      hit_d   <= bus.hit;
      pending <= pending_next;
      ones_q  <= ones_next;
      tens_q  <= tens_next;
      huns_q  <= huns_next;
      thous_q <= thous_next;
      sat_q   <= sat_next;
    end
  end

  // Next-state and datapath logic. Clear wins over everything. In IDLE a
  // queued hit is always served before a new edge; if both occur in the same
  // cycle the new edge takes the freed queue slot, so pending is unchanged.
  // Outside IDLE a new edge is queued, and dropped once the queue is full.
  // After saturation the FSM still walks through ADD_ONES so queued hits
  // drain, but the digits are left frozen at 9999.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    ones_next    = ones_q;
    tens_next    = tens_q;
    huns_next    = huns_q;
    thous_next   = thous_q;
    sat_next     = sat_q;

    if (bus.clear) begin
      state_next   = IDLE;
      pending_next = '0;
      ones_next    = 4'd0;
      tens_next    = 4'd0;
      huns_next    = 4'd0;
      thous_next   = 4'd0;
      sat_next     = 1'b0;
    end else begin
      if (state == IDLE) begin
        if (pending != '0) begin
          state_next = ADD_ONES;
          if (!hit_edge) begin
            pending_next = pending - PEND_ONE;
          end
        end else if (hit_edge) begin
          state_next = ADD_ONES;
        end
      end else if (hit_edge && (pending != PEND_MAX)) begin
        pending_next = pending + PEND_ONE;
      end

      case (state)
        ADD_ONES: begin
          if (sat_q) begin
            state_next = IDLE;
          end else if (ones_sum > 5'd9) begin
            ones_next  = ones_wrap;
            state_next = ADD_TENS;
          end else begin
            ones_next  = ones_q + POINTS4;
            state_next = IDLE;
          end
        end
        ADD_TENS: begin
          if (tens_q == 4'd9) begin
            tens_next  = 4'd0;
            state_next = ADD_HUNS;
          end else begin
            tens_next  = tens_q + 4'd1;
            state_next = IDLE;
          end
        end
        ADD_HUNS: begin
          if (huns_q == 4'd9) begin
            huns_next  = 4'd0;
            state_next = ADD_THOUS;
          end else begin
            huns_next  = huns_q + 4'd1;
            state_next = IDLE;
          end
        end
        ADD_THOUS: begin
          if (thous_q == 4'd9) begin
            ones_next  = 4'd9;
            tens_next  = 4'd9;
            huns_next  = 4'd9;
            thous_next = 4'd9;
            sat_next   = 1'b1;
          end else begin
            thous_next = thous_q + 4'd1;
          end
          state_next = IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  // Every output comes straight from a register, so the display never sees
  // combinational glitches; only the busy flag is decoded from the state.
  assign bus.ones      = ones_q;
  assign bus.tens      = tens_q;
  assign bus.huns      = huns_q;
  assign bus.thous     = thous_q;
  assign bus.saturated = sat_q;
  assign bus.busy      = (state != IDLE);

endmodule
